dbg_cmd_parser: RTL

Byte-stream front end of the debug path. It parses command frames arriving from the host link (UART/JTAG byte receiver) and drives the master side of the debug bus (cmd, addr, write data) into the core debug module. It waits for the module's done pulse, or a timeout, and returns a status/response frame on the outgoing byte stream.

---
 rtl/dbg_cmd_parser_if.sv | 43 ++++
 rtl/dbg_cmd_parser.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/dbg_cmd_parser_if.sv
// Debug command parser bundle: host byte link
// in/out plus the debug bus toward the core.
interface dbg_cmd_parser_if;
  logic [7:0]  rx_data_i;
  logic        rx_valid_i;
  logic        rx_ready_o;
  logic [7:0]  tx_data_o;
  logic        tx_valid_o;
  logic        tx_ready_i;
  logic [7:0]  dbg_cmd_o;
  logic [31:0] dbg_addr_o;
  logic [31:0] dbg_wdata_o;
  logic [31:0] dbg_rdata_i;
  logic        dbg_done_i;

  modport master (
    input  rx_data_i,
    input  rx_valid_i,
    output rx_ready_o,
    output tx_data_o,
    output tx_valid_o,
    input  tx_ready_i,
    output dbg_cmd_o,
    output dbg_addr_o,
    output dbg_wdata_o,
    input  dbg_rdata_i,
    input  dbg_done_i
  );

  modport slave (
    output rx_data_i,
    output rx_valid_i,
    input  rx_ready_o,
    input  tx_data_o,
    input  tx_valid_o,
    output tx_ready_i,
    input  dbg_cmd_o,
    input  dbg_addr_o,
    input  dbg_wdata_o,
    output dbg_rdata_i,
    output dbg_done_i
  );
endinterface

// File: rtl/dbg_cmd_parser.sv
// Debug command parser: byte frames in, debug
// bus transaction, status/response bytes out.
module dbg_cmd_parser #(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic clk,
  input  logic rstn_i,
  dbg_cmd_parser_if.master bus
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TMO_MAX = TW'(TIMEOUT_CYCLES);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_ADDR = 3'd1;
  localparam logic [2:0] S_DATA = 3'd2;
  localparam logic [2:0] S_EXEC = 3'd3;
  localparam logic [2:0] S_RESP = 3'd4;
  localparam logic [2:0] S_ERR  = 3'd5;

  logic [2:0]    state_q, state_d;
  logic [7:0]    cmd_q, cmd_d;
  logic [7:0]    dbg_cmd_q, dbg_cmd_d;
  logic [31:0]   addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [31:0]   rdata_q, rdata_d;
  logic [1:0]    bcnt_q, bcnt_d;
  logic [2:0]    rcnt_q, rcnt_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [7:0]    tx_data_q, tx_data_d;
  logic          tx_valid_q, tx_valid_d;

  logic rx_ready;
  logic rx_fire;
  logic tx_fire;

  assign rx_ready = (state_q == S_IDLE) |
                    (state_q == S_ADDR) |
                    (state_q == S_DATA);
  assign rx_fire  = bus.rx_valid_i & rx_ready;
  assign tx_fire  = tx_valid_q & bus.tx_ready_i;

  assign bus.rx_ready_o  = rx_ready;
  assign bus.tx_data_o   = tx_data_q;
  assign bus.tx_valid_o  = tx_valid_q;
  assign bus.dbg_cmd_o   = dbg_cmd_q;
  assign bus.dbg_addr_o  = addr_q;
  assign bus.dbg_wdata_o = wdata_q;

  // Frame parse, bus execute and response sequencing
  always_comb begin
    state_d    = state_q;
    cmd_d      = cmd_q;
    dbg_cmd_d  = dbg_cmd_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
    bcnt_d     = bcnt_q;
    rcnt_d     = rcnt_q;
    tmo_d      = tmo_q;
    tx_data_d  = tx_data_q;
    tx_valid_d = tx_valid_q;
    case (state_q)
      S_IDLE: begin
        if (rx_fire) begin
          cmd_d = bus.rx_data_i;
          case (bus.rx_data_i)
            8'h01, 8'h02: begin
              state_d   = S_EXEC;
              dbg_cmd_d = bus.rx_data_i;
              tmo_d     = TW'(1);
            end
            8'h03, 8'h04: begin
              state_d = S_ADDR;
              bcnt_d  = 2'd0;
            end
            default: begin
              state_d    = S_ERR;
              tx_valid_d = 1'b1;
              tx_data_d  = 8'hEE;
            end
          endcase
        end
      end
      S_ADDR: begin
        if (rx_fire) begin
          addr_d[{bcnt_q, 3'b000} +: 8] = bus.rx_data_i;
          bcnt_d = bcnt_q + 2'd1;
          if (bcnt_q == 2'd3) begin
            if (cmd_q == 8'h03) begin
              state_d   = S_EXEC;
              dbg_cmd_d = cmd_q;
              tmo_d     = TW'(1);
            end else begin
              state_d = S_DATA;
            end
          end
        end
      end
      S_DATA: begin
        if (rx_fire) begin
          wdata_d[{bcnt_q, 3'b000} +: 8] = bus.rx_data_i;
          bcnt_d = bcnt_q + 2'd1;
          if (bcnt_q == 2'd3) begin
            state_d   = S_EXEC;
            dbg_cmd_d = cmd_q;
            tmo_d     = TW'(1);
          end
        end
      end
      S_EXEC: begin
        if (bus.dbg_done_i) begin
          if (cmd_q == 8'h03) rdata_d = bus.dbg_rdata_i;
          dbg_cmd_d  = 8'h00;
          tx_valid_d = 1'b1;
          tx_data_d  = 8'h5A;
          rcnt_d     = 3'd0;
          state_d    = S_RESP;
        end else if (tmo_q == TMO_MAX) begin
          dbg_cmd_d  = 8'h00;
          tx_valid_d = 1'b1;
          tx_data_d  = 8'hE1;
          state_d    = S_ERR;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      S_RESP: begin
        if (tx_fire) begin
          if (cmd_q == 8'h03 && rcnt_q != 3'd4) begin
            tx_data_d = rdata_q[{rcnt_q[1:0], 3'b000} +: 8];
            rcnt_d    = rcnt_q + 3'd1;
          end else begin
            tx_valid_d = 1'b0;
            state_d    = S_IDLE;
          end
        end
      end
      S_ERR: begin
        if (tx_fire) begin
          tx_valid_d = 1'b0;
          state_d    = S_IDLE;
        end
      end
      default: begin
        state_d    = S_IDLE;
        dbg_cmd_d  = 8'h00;
        tx_valid_d = 1'b0;
      end
    endcase
  end

  // State and datapath registers, async active-low reset
  always_ff @(posedge clk or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q    <= S_IDLE;
      cmd_q      <= 8'h00;
      dbg_cmd_q  <= 8'h00;
      addr_q     <= 32'h0;
      wdata_q    <= 32'h0;
      rdata_q    <= 32'h0;
      bcnt_q     <= 2'd0;
      rcnt_q     <= 3'd0;
      tmo_q      <= '0;
      tx_data_q  <= 8'h00;
      tx_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cmd_q      <= cmd_d;
      dbg_cmd_q  <= dbg_cmd_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      rdata_q    <= rdata_d;
      bcnt_q     <= bcnt_d;
      rcnt_q     <= rcnt_d;
      tmo_q      <= tmo_d;
      tx_data_q  <= tx_data_d;
      tx_valid_q <= tx_valid_d;
    end
  end

endmodule
